// File: rtl/sfifo_arb_pkg.sv
// Shared types and helpers for the sfifo write-side round-robin arbiter.
// Optional build macro used by the arbiter: SFIFO_ARB_PKT_LOCK_EN.
package sfifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Index width that stays at least one bit for degenerate sizes.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sfifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: first set request strictly after 'last',
// wrapping, via a double-width masked priority encoder.
module rr_pick
  import sfifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic               found,
  output logic [IW-1:0]      pick
);

  localparam int unsigned DW = 2 * NUM_REQ;

  logic [DW-1:0] dbl;
  logic [DW-1:0] masked;

  // Upper copy guarantees a hit for any request at or below 'last'.
  always_comb begin
    dbl   = {req, req};
    found = |req;
    pick  = '0;
    for (int i = 0; i < int'(DW); i++) begin
      masked[i] = dbl[i] & (i > int'(last));
    end
    for (int i = int'(DW) - 1; i >= 0; i--) begin
      if (masked[i]) begin
        pick = (i >= int'(NUM_REQ)) ? IW'(i - int'(NUM_REQ)) : IW'(i);
      end
    end
  end

endmodule

// File: rtl/sfifo_wr_arb.sv
// Round-robin write-side arbiter sharing one sfifo write port among producers.
// Build macro SFIFO_ARB_PKT_LOCK_EN switches burst-limit release to packet-last release.
module sfifo_wr_arb
  import sfifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BURST = 4,
  localparam int unsigned IW       = idx_width(NUM_REQ)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_data,
`ifdef SFIFO_ARB_PKT_LOCK_EN
  input  logic [NUM_REQ-1:0]       i_req_last,
`endif
  output logic [NUM_REQ-1:0]       o_req_ready,
  input  logic                     i_fifo_full,
  output logic                     o_fifo_wr_en,
  output logic [WIDTH-1:0]         o_fifo_data,
  output logic [IW-1:0]            o_grant_id,
  output logic                     o_busy
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     last_q, last_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              found;
  logic [IW-1:0]     pick;
  logic              own_valid;
  logic [WIDTH-1:0]  own_data;
  logic              release_burst;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req   (i_req_valid),
    .last  (last_q),
    .found (found),
    .pick  (pick)
  );

`ifdef SFIFO_ARB_PKT_LOCK_EN
  logic own_last;
`endif

  // Owner-selected request signals.
  always_comb begin
    own_valid = 1'b0;
    own_data  = '0;
`ifdef SFIFO_ARB_PKT_LOCK_EN
    own_last  = 1'b0;
`endif
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (IW'(k) == owner_q) begin
        own_valid = i_req_valid[k];
        own_data  = i_req_data[k*WIDTH +: WIDTH];
`ifdef SFIFO_ARB_PKT_LOCK_EN
        own_last  = i_req_last[k];
`endif
      end
    end
  end

`ifdef SFIFO_ARB_PKT_LOCK_EN
  assign release_burst = own_last;
`else
  assign release_burst = ((cnt_q + CW'(1)) == CW'(MAX_BURST));
`endif

  // Next-state and write-port outputs; reset cycle suppresses any write.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    o_req_ready  = '0;
    o_fifo_wr_en = 1'b0;
    o_fifo_data  = '0;
    case (state_q)
      ARB_IDLE: begin
        if (found) begin
          owner_d = pick;
          cnt_d   = '0;
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (i_rst_n) begin
          o_fifo_data  = own_data;
          o_fifo_wr_en = own_valid & ~i_fifo_full;
          for (int unsigned k = 0; k < NUM_REQ; k++) begin
            o_req_ready[k] = (IW'(k) == owner_q) & ~i_fifo_full;
          end
        end
        if (!own_valid) begin
          state_d = ARB_IDLE;
          last_d  = owner_q;
        end else if (!i_fifo_full) begin
          cnt_d = cnt_q + CW'(1);
          if (release_burst) begin
            state_d = ARB_IDLE;
            last_d  = owner_q;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // last_q resets to the top index so requester 0 wins first.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_busy     = (state_q == ARB_GRANT);
  assign o_grant_id = owner_q;

endmodule

// File: doc/sfifo_wr_arb.md
Name: sfifo_wr_arb

Overview:
- Round-robin write-side arbiter that shares one synchronous FIFO (sfifo) among NUM_REQ producers.
- Each producer uses a valid/ready handshake. The arbiter grants one owner at a time and forwards its data straight to the FIFO write port.
- A grant is held for up to MAX_BURST accepted words, then the next requester in rotation gets the grant. This gives fair, starvation-free access.
- Backpressure comes from the FIFO full flag.

Parameters:
- NUM_REQ, 4: number of producers; must be ≥2.
- WIDTH, 8: data width; must match the sfifo WIDTH.
- MAX_BURST, 4: maximum consecutive accepted words per grant; must be ≥1.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset; synchronous, active-low
- i_req_valid  in  NUM_REQ  per-producer word valid
- i_req_data  in  NUM_REQ*WIDTH  packed producer data; requester k occupies bits [k*WIDTH +: WIDTH]
- o_req_ready  out  NUM_REQ  per-producer accept
- i_fifo_full  in  1  sfifo o_full
- o_fifo_wr_en  out  1  drives sfifo i_wr_en
- o_fifo_data  out  WIDTH  drives sfifo i_data_in
- o_grant_id  out  $clog2(NUM_REQ)  current owner index; valid only when o_busy=1
- o_busy  out  1  1 while in GRANT state

Behaviour:
- Reset (i_rst_n=0 at a rising edge of i_clk):
  - state=IDLE, burst_cnt=0, last_owner=NUM_REQ-1, so requester 0 has first priority.
  - All outputs are 0.
  - Reset mid-burst abandons the grant. No write is issued in the reset cycle.
- FSM states: IDLE, GRANT.
- IDLE:
  - o_req_ready=0, o_fifo_wr_en=0.
  - If any i_req_valid is set, pick the first set bit scanning from last_owner+1 upward, wrapping modulo NUM_REQ.
  - Next cycle: owner <= pick, burst_cnt <= 0, state <= GRANT.
  - Arbitration therefore costs exactly one bubble cycle.
- GRANT:
  - o_req_ready[owner] = ~i_fifo_full. All other ready bits are 0.
  - Transfer occurs when i_req_valid[owner] & o_req_ready[owner].
  - o_fifo_wr_en = transfer (combinational, zero latency).
  - o_fifo_data = i_req_data[owner] in every GRANT cycle; 0 in IDLE.
- Burst count: each transfer increments burst_cnt, which is $clog2(MAX_BURST+1) bits wide and saturates only through the release rule below.
- Release to IDLE, last_owner <= owner, when either:
  - (a) a transfer makes burst_cnt reach MAX_BURST, or
  - (b) i_req_valid[owner]=0 in a GRANT cycle. No transfer occurs that cycle.
- FIFO full:
  - Grant is held and burst_cnt is frozen.
  - Full cycles never count toward the burst and never cause release.
- Simultaneous valid from every requester:
  - Service order is 0,1,2,3,0,…
  - Each requester gets MAX_BURST words per turn.
  - Each grant is followed by one IDLE cycle.
- A requester that drops valid mid-burst loses the grant. Its next grant comes only after rotation.
- The producer must hold valid and data stable until ready. The arbiter does not check this.
- No FIFO read-side interaction. Empty and pass-through handling stay inside sfifo.

Optional Feature:
- Macro: SFIFO_ARB_PKT_LOCK_EN.
- When defined:
  - Adds input i_req_last (NUM_REQ bits).
  - Release rule (a) becomes: a transfer with i_req_last[owner]=1.
  - MAX_BURST is ignored, so packets are never interleaved in the FIFO.
  - Rule (b) still applies.
- When undefined: no i_req_last port; burst-limit release as above.

Decomposition:
- Package sfifo_arb_pkg:
  - typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e.
  - Function clog2-safe index width helper.
- Sub-module rr_pick: purely combinational.
  - Inputs: req vector, last index.
  - Outputs: found flag, picked index.
  - Implemented by a double-width masked priority encoder.
- The top holds the FSM, counters and muxes.

Test Plan:
- Reset to idle: drive reset for 3 cycles, then release with all valid=0 → o_busy=0, o_fifo_wr_en=0, o_req_ready=0000 indefinitely.
- Single requester: req2 valid with data 0xA0..0xA5 (6 words), FIFO not full, MAX_BURST=4.
  - Cycle 1: IDLE bubble.
  - Next 4 cycles: writes 0xA0–0xA3 with o_grant_id=2.
  - Then one IDLE cycle, then 0xA4–0xA5.
- Fairness: all 4 requesters continuously valid → FIFO write sequence is 4 words from req0, 4 from req1, 4 from req2, 4 from req3, then req0 again, with 1 bubble between grants.
- Backpressure: req1 granted; assert i_fifo_full for 5 cycles after 2 transfers → ready1=0, no wr_en, grant held. After full drops, exactly 2 more words are accepted before release.
- Valid drop and reset mid-burst:
  - req0 drops valid after 1 word → release next edge, and req3 (valid) is granted next.
  - Assert i_rst_n=0 mid-GRANT → next cycle all outputs 0 and req0 gets priority again.
- Packet lock (with SFIFO_ARB_PKT_LOCK_EN): req0 sends a 7-word packet with last on word 7 while req1 is valid → all 7 words are contiguous, then req1 is granted.
